pe_s10_adder_tree: RTL

//  Parametrised, pipelined signed multi-operand adder tree for the PE array dot-product path.
//  - Generalises the two-operand S10 fractal adder (operands a,b plus carry bits s0,s1) to NUM_IN operands.
//  - Each tree level is built from that 2-input adder cell and followed by one register stage.
//  - Two carry-in bits are injected as a rounding bias.
//  - Optional accumulator folds multiple beats into one result.

---
 rtl/pe_s10_adder_tree.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pe_s10_adder_tree.sv
// pe_s10_adder_tree: pipelined signed multi-operand adder tree for the PE
// dot-product path. NUM_IN operands are reduced pairwise by a 2-input adder
// cell (two operands plus two carry bits), with one register per tree level.
// cin0/cin1 enter as the carry bits of the first level-1 pair, which makes
// them a rounding bias on the total.
// Optional feature macro: PE_ADDER_TREE_ACC_EN adds an accumulator stage that
// folds beats into one result per in_last-terminated group.
module pe_s10_adder_tree #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 8,
`ifdef PE_ADDER_TREE_ACC_EN
  parameter int ACC_W  = 32,
`endif
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int OUT_W  = WIDTH + LEVELS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    cin0,
  input  logic                    cin1,
  output logic                    out_valid,
`ifdef PE_ADDER_TREE_ACC_EN
  output logic [ACC_W-1:0]        out_data
`else
  output logic [OUT_W-1:0]        out_data
`endif
);

  // The 2-input S10 cell. Every node is carried at the full tree width,
  // sign-extended, so each level's sum is exact and never wraps.
  function automatic logic [OUT_W-1:0] addCell(input logic [OUT_W-1:0] a,
                                               input logic [OUT_W-1:0] b,
                                               input logic s0,
                                               input logic s1);
    return a + b + OUT_W'(s0) + OUT_W'(s1);
  endfunction

  // Nodes use heap numbering: node 1 is the root, node n has children 2n and
  // 2n+1. Nodes NUM_IN/2 .. NUM_IN-1 form level 1 and take operand pairs
  // directly; node NUM_IN/2 is pair 0 and therefore gets the carry bits.
  logic [OUT_W-1:0]  node_q [1:NUM_IN-1];
  logic [OUT_W-1:0]  node_d [1:NUM_IN-1];
  logic [NUM_IN-1:1] load;
  logic [LEVELS-1:0] valid_q;

  for (genvar n = 1; n < NUM_IN; n++) begin : g_node
    // Pipeline stage this node's register belongs to (0 = level 1).
    localparam int STAGE = LEVELS - $clog2(n + 1);

    if (n >= NUM_IN / 2) begin : g_leaf
      logic [OUT_W-1:0] opA;
      logic [OUT_W-1:0] opB;
      assign opA = OUT_W'(signed'(in_data[(2*n-NUM_IN)*WIDTH +: WIDTH]));
      assign opB = OUT_W'(signed'(in_data[(2*n-NUM_IN+1)*WIDTH +: WIDTH]));
      if (n == NUM_IN / 2) begin : g_bias
        assign node_d[n] = addCell(opA, opB, cin0, cin1);
      end else begin : g_plain
        assign node_d[n] = addCell(opA, opB, 1'b0, 1'b0);
      end
    end else begin : g_inner
      assign node_d[n] = addCell(node_q[2*n], node_q[2*n+1], 1'b0, 1'b0);
    end

    // Data registers only load behind a valid beat, so bubbles leave the
    // last result parked on the output instead of toggling the tree.
    if (STAGE == 0) begin : g_load0
      assign load[n] = in_valid;
    end else begin : g_loadN
      assign load[n] = valid_q[STAGE-1];
    end
  end

  // Tree data and valid shift register; enable low freezes the whole pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 1; n < NUM_IN; n++) node_q[n] <= '0;
      valid_q <= '0;
    end else if (enable) begin
      for (int n = 1; n < NUM_IN; n++) begin
        if (load[n]) node_q[n] <= node_d[n];
      end
      valid_q <= {valid_q[LEVELS-2:0], in_valid};
    end
  end

`ifdef PE_ADDER_TREE_ACC_EN
  logic [LEVELS-1:0] last_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  accSum;
  logic [ACC_W-1:0]  out_q;
  logic              outValid_q;

  assign accSum = acc_q + ACC_W'(signed'(node_q[1]));

  // Group-end marker travelling in lockstep with the valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else if (enable) begin
      last_q <= {last_q[LEVELS-2:0], in_last};
    end
  end

  // Accumulator: fold every valid tree result, emit and restart on last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      out_q      <= '0;
      outValid_q <= 1'b0;
    end else if (enable) begin
      outValid_q <= valid_q[LEVELS-1] & last_q[LEVELS-1];
      if (valid_q[LEVELS-1]) begin
        if (last_q[LEVELS-1]) begin
          out_q <= accSum;
          acc_q <= '0;
        end else begin
          acc_q <= accSum;
        end
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = out_q;
`else
  logic unused_last;
  assign unused_last = in_last;

  assign out_valid = valid_q[LEVELS-1];
  assign out_data  = node_q[1];
`endif

endmodule
